// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
// Two-entry skid buffer between the ALU and the register-file write port.
// Entries leave in FIFO order. On commit, an entry's flags update the
// architectural status register {C,S,V,Z} and feed a sticky overflow bit.
// The head entry is re-registered into out_* so the outputs come straight
// from flops. in_ready depends only on the occupancy register, so there is
// no combinational path from out_ready to in_ready.
module alu_writeback_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_carry,
   input  logic              in_sign,
   input  logic              in_ovf,
   input  logic              in_zero,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_wen,
   input  logic              in_flag_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_wen,
   output logic [3:0]        status_q,
   output logic              sticky_ovf,
   input  logic              clr_sticky
);

   // Buffer storage (data only, never reset)
   logic [DATA_W-1:0] res_p0 [0:1];
   logic [REG_AW-1:0] rd_p0  [0:1];
   logic [3:0]        flg_p0 [0:1];
   logic [1:0]        wen_p0;
   logic [1:0]        fwe_p0;

   // Control state
   logic [1:0] count_q;
   logic       head_q;
   logic       tail_q;

   logic       push;
   logic       pop;
   logic [1:0] count_n;
   logic       head_n;
   logic       wen_eff;
   logic       fill_from_in;

   logic [DATA_W-1:0] nxt_result;
   logic [REG_AW-1:0] nxt_rd;
   logic              nxt_wen;

   logic [3:0] head_flg;
   logic       head_fwe;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Register 0 is hard-wired, so a write to it is squashed at capture time
   assign wen_eff   = in_wen & (in_rd != '0);

   assign head_flg  = flg_p0[head_q];
   assign head_fwe  = fwe_p0[head_q];

   // Next occupancy and head pointer after this cycle's push/pop
   always_comb begin
      count_n = count_q;
      unique case ({push, pop})
         2'b10:   count_n = count_q + 2'd1;
         2'b01:   count_n = count_q - 2'd1;
         default: count_n = count_q;
      endcase
      head_n = head_q ^ pop;
   end

   // Select the entry that will be at the head after this edge: it is either
   // already stored, or it is the incoming word landing in the head slot
   always_comb begin
      fill_from_in = push & (tail_q == head_n);
      if (fill_from_in) begin
         nxt_result = in_result;
         nxt_rd     = in_rd;
         nxt_wen    = wen_eff;
      end else begin
         nxt_result = res_p0[head_n];
         nxt_rd     = rd_p0[head_n];
         nxt_wen    = wen_p0[head_n];
      end
   end

   // Write the accepted entry at the tail slot
   always_ff @(posedge clk) begin
      if (push) begin
         res_p0[tail_q] <= in_result;
         rd_p0[tail_q]  <= in_rd;
         flg_p0[tail_q] <= {in_carry, in_sign, in_ovf, in_zero};
         wen_p0[tail_q] <= wen_eff;
         fwe_p0[tail_q] <= in_flag_we;
      end
   end

   // Occupancy and 1-bit ring pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
      end else begin
         count_q <= count_n;
         head_q  <= head_n;
         tail_q  <= tail_q ^ push;
      end
   end

   // Output register: load the next head, or hold data and drop wen when empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_result <= '0;
         out_rd     <= '0;
         out_wen    <= 1'b0;
      end else if (count_n != 2'd0) begin
         out_result <= nxt_result;
         out_rd     <= nxt_rd;
         out_wen    <= nxt_wen;
      end else begin
         out_wen    <= 1'b0;
      end
   end

   // Commit flags in pop order; a set in the same cycle as a clear takes priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q   <= 4'b0000;
         sticky_ovf <= 1'b0;
      end else begin
         if (pop && head_fwe) begin
            status_q <= head_flg;
         end
         if (pop && head_fwe && head_flg[1]) begin
            sticky_ovf <= 1'b1;
         end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
         end
      end
   end

endmodule
